rf_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single register-file write port (a3 / write_data / write_enable) between two producers: the ALU result path and the load unit.
- Each producer has a one-entry holding slot with a valid/ready handshake.
- The block arbitrates between filled slots, preserves write-after-write order to the same register, and discards writes to x0.
- It sits between the execute/memory stages and register_file, and exports a pending-destination mask for the hazard unit.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_wb_slot.sv | 45 ++++
 rtl/rf_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and encodings for the register-file write-back path.
package rf_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned STARVE_W     = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LD   = 2'd2
    } gnt_e;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry write-back holding slot; an accepted write to x0 completes
// the handshake but never occupies the slot.
module rf_wb_slot
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned RD_W   = ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              ready_c,
    output logic              fill_c,
    output logic              full,
    output logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] data
);

    logic accept_c;

    // Ready never looks at valid, so producers can use it to decide.
    always_comb begin
        ready_c  = !rst && (!full || grant);
        accept_c = in_valid && ready_c;
        fill_c   = accept_c && (in_rd != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            rd   <= '0;
            data <= '0;
        end else if (accept_c) begin
            full <= fill_c;
            rd   <= in_rd;
            data <= in_data;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the ALU and load paths,
// keeping same-register writes in order and bounding ALU starvation.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned XLEN         = rf_pkg::XLEN,
    parameter int unsigned ADDR_W       = rf_pkg::ADDR_W,
    parameter int unsigned STARVE_LIMIT = rf_pkg::STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_a3,
    output logic [XLEN-1:0]      rf_wd,
    output logic [2**ADDR_W-1:0] pend_mask
);

    localparam int unsigned NR = 2**ADDR_W;

    gnt_e                gnt_c;
    logic                alu_full, ld_full;
    logic                alu_fill_c, ld_fill_c;
    logic [ADDR_W-1:0]   alu_slot_rd, ld_slot_rd;
    logic [XLEN-1:0]     alu_slot_data, ld_slot_data;

    logic [STARVE_W-1:0] starve_cnt, starve_nxt;
    logic                ld_older, ld_older_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   a3_nxt;
    logic [XLEN-1:0]     wd_nxt;

    rf_wb_slot #(.DATA_W(XLEN), .RD_W(ADDR_W)) u_alu_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (alu_valid),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (gnt_c == GNT_ALU),
        .ready_c  (alu_ready),
        .fill_c   (alu_fill_c),
        .full     (alu_full),
        .rd       (alu_slot_rd),
        .data     (alu_slot_data)
    );

    rf_wb_slot #(.DATA_W(XLEN), .RD_W(ADDR_W)) u_ld_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ld_valid),
        .in_rd    (ld_rd),
        .in_data  (ld_data),
        .grant    (gnt_c == GNT_LD),
        .ready_c  (ld_ready),
        .fill_c   (ld_fill_c),
        .full     (ld_full),
        .rd       (ld_slot_rd),
        .data     (ld_slot_data)
    );

    // Grant priority: same-rd ordering, then starvation relief, then load.
    always_comb begin
        gnt_c = GNT_NONE;
        if (alu_full && ld_full && (alu_slot_rd == ld_slot_rd)) begin
            gnt_c = ld_older ? GNT_LD : GNT_ALU;
        end else if (alu_full && (starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
            gnt_c = GNT_ALU;
        end else if (ld_full) begin
            gnt_c = GNT_LD;
        end else if (alu_full) begin
            gnt_c = GNT_ALU;
        end
    end

    // Next-state for order flag, starvation counter and output stage.
    always_comb begin
        starve_nxt   = '0;
        ld_older_nxt = ld_older;
        we_nxt       = 1'b0;
        a3_nxt       = rf_a3;
        wd_nxt       = rf_wd;

        if (alu_full && (gnt_c != GNT_ALU)) begin
            starve_nxt = (starve_cnt == STARVE_W'(STARVE_LIMIT))
                       ? starve_cnt : starve_cnt + STARVE_W'(1);
        end

        // Whichever slot fills later is younger; a tie makes load older.
        if (alu_fill_c) begin
            ld_older_nxt = 1'b1;
        end else if (ld_fill_c) begin
            ld_older_nxt = 1'b0;
        end

        if (gnt_c == GNT_ALU) begin
            we_nxt = 1'b1;
            a3_nxt = alu_slot_rd;
            wd_nxt = alu_slot_data;
        end else if (gnt_c == GNT_LD) begin
            we_nxt = 1'b1;
            a3_nxt = ld_slot_rd;
            wd_nxt = ld_slot_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            ld_older   <= 1'b0;
            rf_we      <= 1'b0;
            rf_a3      <= '0;
            rf_wd      <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            ld_older   <= ld_older_nxt;
            rf_we      <= we_nxt;
            rf_a3      <= a3_nxt;
            rf_wd      <= wd_nxt;
        end
    end

    // Destinations still in flight, for the hazard unit.
    always_comb begin
        pend_mask = '0;
        if (alu_full) begin
            pend_mask = pend_mask | (NR'(1) << alu_slot_rd);
        end
        if (ld_full) begin
            pend_mask = pend_mask | (NR'(1) << ld_slot_rd);
        end
        if (rf_we) begin
            pend_mask = pend_mask | (NR'(1) << rf_a3);
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboarded bench for rf_wb_arbiter: expected writes are queued in
// program order of the arbitration rules and popped as rf_we fires.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                alu_valid = 1'b0;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_rd = '0;
    logic [XLEN-1:0]     alu_data = '0;
    logic                ld_valid = 1'b0;
    logic                ld_ready;
    logic [ADDR_W-1:0]   ld_rd = '0;
    logic [XLEN-1:0]     ld_data = '0;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_a3;
    logic [XLEN-1:0]     rf_wd;
    logic [NUM_REGS-1:0] pend_mask;

    logic [ADDR_W+XLEN-1:0] sb_q [$];
    logic [XLEN-1:0]        rf_shadow [NUM_REGS];
    int n_checks = 0;
    int n_pass   = 0;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W+XLEN-1:0] wr(input int rd, input logic [XLEN-1:0] d);
        return {ADDR_W'(rd), d};
    endfunction

    // Pops one expected write per cycle that rf_we is high.
    task automatic mon();
        logic [ADDR_W+XLEN-1:0] exp;
        if (!rst && rf_we) begin
            rf_shadow[rf_a3] = rf_wd;
            if (sb_q.size() == 0) begin
                check("unexpected_wr", {rf_a3, rf_wd}, '0);
            end else begin
                exp = sb_q.pop_front();
                check("wb", {rf_a3, rf_wd}, exp);
            end
        end
    endtask

    // Advance one cycle; inputs change and checks sample at posedge+1.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NUM_REGS; i++) rf_shadow[i] = '0;

        #1;
        check("rst_alu_rdy", alu_ready, 0);
        check("rst_ld_rdy", ld_ready, 0);
        check("rst_we", rf_we, 0);
        check("rst_a3", rf_a3, 0);
        check("rst_wd", rf_wd, 0);
        check("rst_pend", pend_mask, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_alu_rdy", alu_ready, 1);
        tick();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h0000_1234;
        sb_q.push_back(wr(5, 32'h0000_1234));
        check("t1_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("t1_pend_e", pend_mask, 64'h20);
        check("t1_we_e", rf_we, 0);
        tick();
        check("t1_wr", {rf_we, rf_a3, rf_wd}, {1'b1, 5'd5, 32'h0000_1234});
        check("t1_pend_e1", pend_mask, 64'h20);
        tick();
        check("t1_we_drop", rf_we, 0);
        check("t1_pend_drop", pend_mask, 0);

        // Simultaneous requests: load first, ALU waits one cycle
        alu_valid = 1'b1; alu_rd = 3; alu_data = 32'hA;
        ld_valid  = 1'b1; ld_rd  = 4; ld_data  = 32'hB;
        sb_q.push_back(wr(4, 32'hB));
        sb_q.push_back(wr(3, 32'hA));
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        check("t2_alu_wait", alu_ready, 0);
        check("t2_ld_rdy", ld_ready, 1);
        tick();
        check("t2_first", {rf_we, rf_a3}, {1'b1, 5'd4});
        check("t2_alu_gnt", alu_ready, 1);
        tick();
        check("t2_second", {rf_we, rf_a3, rf_wd}, {1'b1, 5'd3, 32'hA});
        tick();
        check("t2_idle", rf_we, 0);

        // Load stream starves ALU for exactly STARVE_LIMIT cycles
        for (int k = 10; k <= 12; k++) sb_q.push_back(wr(k, 32'(k) << 8));
        sb_q.push_back(wr(9, 32'h99));
        sb_q.push_back(wr(13, 32'(13) << 8));
        sb_q.push_back(wr(14, 32'(14) << 8));
        n = 0;
        for (int c = 0; c < 7; c++) begin
            alu_valid = (c == 0); alu_rd = 9; alu_data = 32'h99;
            ld_valid  = (c <= 5); ld_rd = ADDR_W'(10 + n); ld_data = 32'(10 + n) << 8;
            check($sformatf("t3_alu_rdy_c%0d", c), alu_ready, (c == 0 || c >= 4));
            check($sformatf("t3_ld_rdy_c%0d", c), ld_ready, (c != 4));
            if (ld_valid && ld_ready) n++;
            tick();
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        tick();
        tick();
        check("t3_drained", pend_mask, 0);

        // Write to x0 is swallowed
        alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        check("t4_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("t4_pend", pend_mask, 0);
        check("t4_rdy_after", alu_ready, 1);
        tick();
        check("t4_we", rf_we, 0);
        tick();

        // Same rd back to back across producers
        alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h1;
        sb_q.push_back(wr(7, 32'h1));
        sb_q.push_back(wr(7, 32'h2));
        tick();
        alu_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 7; ld_data = 32'h2;
        check("t5_ld_rdy", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        check("t5_first", {rf_we, rf_a3, rf_wd}, {1'b1, 5'd7, 32'h1});
        check("t5_pend", pend_mask, 64'h80);
        tick();
        check("t5_second", {rf_we, rf_a3, rf_wd}, {1'b1, 5'd7, 32'h2});
        tick();
        tick();
        check("t5_rf7", rf_shadow[7], 32'h2);

        // Older ALU entry beats a younger load to the same rd
        alu_valid = 1'b1; alu_rd = 6;  alu_data = 32'h66;
        ld_valid  = 1'b1; ld_rd  = 20; ld_data  = 32'h20;
        sb_q.push_back(wr(20, 32'h20));
        sb_q.push_back(wr(6, 32'h66));
        sb_q.push_back(wr(6, 32'h77));
        tick();
        alu_valid = 1'b0;
        ld_rd = 6; ld_data = 32'h77;
        check("t5b_ld_rdy", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        check("t5b_alu_gnt", {alu_ready, ld_ready}, 2'b10);
        tick();
        tick();
        tick();
        check("t5b_rf6", rf_shadow[6], 32'h77);

        // Reset mid-cycle with both slots full
        alu_valid = 1'b1; alu_rd = 11; alu_data = 32'hB0B;
        ld_valid  = 1'b1; ld_rd  = 12; ld_data  = 32'hC0C;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        check("t6_pend_pre", pend_mask, 64'h1800);
        #2;
        rst = 1'b1;
        #1;
        check("t6_we", rf_we, 0);
        check("t6_pend", pend_mask, 0);
        check("t6_rdy", {alu_ready, ld_ready}, 2'b00);
        @(posedge clk);
        #1;
        check("t6_we_edge", rf_we, 0);
        rst = 1'b0;
        tick();
        check("t6_we_after", rf_we, 0);
        check("t6_pend_after", pend_mask, 0);
        alu_valid = 1'b1; alu_rd = 13; alu_data = 32'hD00D;
        sb_q.push_back(wr(13, 32'hD00D));
        tick();
        alu_valid = 1'b0;
        tick();
        check("t6_fresh", {rf_we, rf_a3, rf_wd}, {1'b1, 5'd13, 32'hD00D});
        tick();
        tick();

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
